if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Dual-slot fetch stage for the in-order superscalar CPU. Drives both instruction-memory
//  read addresses (addr0/addr1) and captures the two returned instructions into a 2-slot
//  IF/ID holding register. The memory samples the addresses on negedge clk, so returned
//  data is valid by the next posedge. Decode reports how many slots it issued (0/1/2);
//  the unit refills without bubbles, honours redirects (branch/jump), stall and HALT.
// PARAMETERS
//  PC_W     14         instruction address width; all PC arithmetic is modulo 2^PC_W
//  INSTR_W  32         instruction width
//  RST_PC   14'h0000   PC value loaded on reset
//  HALT_OP  5'b11111   opcode (instr[31:27]) identifying HALT
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous, active-high reset
//  stall        in   1        freeze PC and slots entirely this cycle
//  redirect     in   1        flush slots, load redirect_pc
//  redirect_pc  in   PC_W     new fetch address
//  consumed     in   2        slots issued by decode this cycle (0,1,2); 3 is illegal
//  instr0_in    in   INSTR_W  memory data for addr0
//  instr1_in    in   INSTR_W  memory data for addr1
//  addr0        out  PC_W     = pc (driven from the PC register, glitch-free)
//  addr1        out  PC_W     = pc+1 mod 2^PC_W
//  if_instr0/1  out  INSTR_W  slot 0 (older) / slot 1 instruction
//  if_pc0/1     out  PC_W     address of each slot
//  if_vld0/1    out  1        slot valid; if_vld1 implies if_vld0
//  halted       out  1        HALT captured; fetch frozen
// BEHAVIOUR
//  - Reset (async): pc=RST_PC; if_vld0/1=0; if_instr*=0; if_pc*=0; halted=0.
//  - Priority per posedge: redirect > stall > halted > normal fill.
//  - Redirect: pc<=redirect_pc; if_vld0/1<=0; halted<=0; consumed/stall ignored.
//    One bubble cycle; the new pair appears the cycle after the redirect.
//  - Stall: all state holds.
//  - Normal: n = if_vld0+if_vld1; r = n-consumed (slots left); f = 2-r slots to fill.
//    r=1: slot0<=old slot1 (instr, pc, vld). Fill from instr0_in first, then instr1_in.
//    Fill addresses start at pc. pc<=pc+f. f=0 means hold.
//    Example: consumed=1 with both slots valid: slot0<=slot1; slot1<=instr0_in@pc; pc+=1.
//  - HALT: a filled instr with [31:27]==HALT_OP is written valid; later fill slots are
//    written invalid. pc<=HALT address+1 and halted<=1. While halted, there are no fills
//    and pc is frozen. Remaining slots still shift and drain on consumed.
//  - Wrap: pc=2^PC_W-1 gives addr1=0. Pair addresses are sequential modulo 2^PC_W.
//  - Illegal: consumed>n or consumed==3 is flagged by an assertion, behaviour undefined.
//  - Outputs are registered only. addr0/addr1 come straight from the pc flop.
// STRUCTURE
//  - Shared package cpu_pkg: PC_W, INSTR_W, opcode field position and opcode constants
//    (HALT_OP and others), plus the IF/ID slot struct {instr, pc, vld}.
//  - No sub-module. Fill/shift mux, HALT compare and pc adder stay inline in one file.
// TESTING
//  1 Reset with a memory image of 0x100..0x10F at addr 0..15, consumed=2 every cycle
//    -> pairs (0,1),(2,3),(4,5) are each valid in consecutive cycles; pc=6 after 3 fills.
//  2 Both slots valid holding (4,5), consumed=1 -> next slots are (5,6), pc+=1.
//    consumed=0 -> slots and pc are unchanged.
//  3 Redirect to 0x0200 while consumed=2 and stall=1 -> next cycle if_vld0/1=0.
//    The cycle after that, slots hold (0x200,0x201).
//  4 HALT at addr 7, fetching pair (6,7) -> slot0 vld, slot1=HALT vld, halted=1, pc=8.
//    HALT at addr 6 -> slot1 invalid. Later cycles issue no fills.
//  5 pc=0x3FFF, consumed=2 -> addr1=0x0000; slots are (0x3FFF,0x0000); pc=0x0001.
//  6 Assert rst mid-stream with halted=1 and slots valid -> all outputs clear immediately.
//    After release, fetch resumes at RST_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field location and encodings,
// and the IF/ID slot record passed from fetch to decode.
package cpu_pkg;

    localparam int PC_W    = 14;
    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [OPC_W-1:0] {
        OP_ALU    = 5'b00000,
        OP_LOAD   = 5'b00001,
        OP_STORE  = 5'b00010,
        OP_BRANCH = 5'b00011,
        OP_JUMP   = 5'b00100,
        OP_HALT   = 5'b11111
    } opcode_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               vld;
    } slot_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Dual-slot instruction fetch: drives a pair of sequential memory addresses and keeps
// a 2-entry IF/ID buffer topped up as decode drains it, with redirect, stall and HALT.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0]  RST_PC  = '0,
    parameter logic [OPC_W-1:0] HALT_OP = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic [1:0]         consumed,
    input  logic [INSTR_W-1:0] instr0_in,
    input  logic [INSTR_W-1:0] instr1_in,
    output logic [PC_W-1:0]    addr0,
    output logic [PC_W-1:0]    addr1,
    output logic [INSTR_W-1:0] if_instr0,
    output logic [INSTR_W-1:0] if_instr1,
    output logic [PC_W-1:0]    if_pc0,
    output logic [PC_W-1:0]    if_pc1,
    output logic               if_vld0,
    output logic               if_vld1,
    output logic               halted
);

    slot_t           slot0, slot1, slot0_nxt, slot1_nxt;
    slot_t           rem, fill_a, fill_b;
    logic [PC_W-1:0] pc, pc1, pc_nxt;
    logic            halted_nxt;
    logic [1:0]      n_vld, r_left;
    logic            halt_a, halt_b;

    always_comb begin
        n_vld  = {1'b0, slot0.vld} + {1'b0, slot1.vld};
        r_left = n_vld - consumed;
        // The surviving entry is whichever slot decode did not take.
        rem    = (consumed == 2'd0) ? slot0 : slot1;
        fill_a = '{instr: instr0_in, pc: pc,  vld: 1'b1};
        fill_b = '{instr: instr1_in, pc: pc1, vld: 1'b1};
        halt_a = (instr0_in[OPC_MSB:OPC_LSB] == HALT_OP);
        halt_b = (instr1_in[OPC_MSB:OPC_LSB] == HALT_OP);

        slot0_nxt  = slot0;
        slot1_nxt  = slot1;
        pc_nxt     = pc;
        halted_nxt = halted;

        if (redirect) begin
            pc_nxt        = redirect_pc;
            slot0_nxt.vld = 1'b0;
            slot1_nxt.vld = 1'b0;
            halted_nxt    = 1'b0;
        end else if (!stall) begin
            case (r_left)
                2'd1: begin
                    slot0_nxt = rem;
                    if (halted) begin
                        slot1_nxt.vld = 1'b0;
                    end else begin
                        slot1_nxt  = fill_a;
                        pc_nxt     = pc1;
                        halted_nxt = halt_a;
                    end
                end
                2'd0: begin
                    if (halted) begin
                        slot0_nxt.vld = 1'b0;
                        slot1_nxt.vld = 1'b0;
                    end else begin
                        slot0_nxt = fill_a;
                        slot1_nxt = fill_b;
                        if (halt_a) begin
                            // Anything fetched behind a HALT must never issue.
                            slot1_nxt.vld = 1'b0;
                            pc_nxt        = pc1;
                            halted_nxt    = 1'b1;
                        end else begin
                            pc_nxt     = pc + PC_W'(2);
                            halted_nxt = halt_b;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // pc+1 is kept in its own flop so addr1 leaves the block without an adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RST_PC;
            pc1    <= RST_PC + PC_W'(1);
            slot0  <= '0;
            slot1  <= '0;
            halted <= 1'b0;
        end else begin
            pc     <= pc_nxt;
            pc1    <= pc_nxt + PC_W'(1);
            slot0  <= slot0_nxt;
            slot1  <= slot1_nxt;
            halted <= halted_nxt;
        end
    end

    assign addr0     = pc;
    assign addr1     = pc1;
    assign if_instr0 = slot0.instr;
    assign if_instr1 = slot1.instr;
    assign if_pc0    = slot0.pc;
    assign if_pc1    = slot1.pc;
    assign if_vld0   = slot0.vld;
    assign if_vld1   = slot1.vld;

    a_consumed_legal: assert property (@(posedge clk) disable iff (rst)
        (!redirect && !stall) |-> (consumed != 2'd3 && consumed <= n_vld));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a negedge-sampling memory model feeds the DUT while
// each cycle's expected slot state is queued at drive time and checked after the edge.
module tb_if_fetch_unit;

    localparam int PW = 14;
    localparam int IW = 32;

    typedef struct {
        logic          v0;
        logic [PW-1:0] p0;
        logic          v1;
        logic [PW-1:0] p1;
        logic          h;
        logic [PW-1:0] pc;
        string         tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic [1:0]    consumed = 2'd0;
    logic [IW-1:0] instr0_in = '0;
    logic [IW-1:0] instr1_in = '0;
    logic [PW-1:0] addr0, addr1, if_pc0, if_pc1;
    logic [IW-1:0] if_instr0, if_instr1;
    logic          if_vld0, if_vld1, halted;

    logic          halt_en = 1'b0;
    logic [PW-1:0] halt_addr = '0;
    int            tests = 0;
    int            failed = 0;
    exp_t          sb[$];

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .consumed(consumed),
        .instr0_in(instr0_in), .instr1_in(instr1_in),
        .addr0(addr0), .addr1(addr1),
        .if_instr0(if_instr0), .if_instr1(if_instr1),
        .if_pc0(if_pc0), .if_pc1(if_pc1),
        .if_vld0(if_vld0), .if_vld1(if_vld1), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        if (halt_en && a == halt_addr) return {5'b11111, 13'd0, a};
        return 32'h0000_0100 + {18'd0, a};
    endfunction

    always @(negedge clk) begin
        instr0_in = mem_word(addr0);
        instr1_in = mem_word(addr1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_vld0"}, 32'(if_vld0), 32'd0);
        check({tag, "_vld1"}, 32'(if_vld1), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_instr0"}, if_instr0, 32'd0);
        check({tag, "_instr1"}, if_instr1, 32'd0);
        check({tag, "_pc0"}, 32'(if_pc0), 32'd0);
        check({tag, "_pc1"}, 32'(if_pc1), 32'd0);
        check({tag, "_addr0"}, 32'(addr0), 32'd0);
        check({tag, "_addr1"}, 32'(addr1), 32'd1);
    endtask

    task automatic step(input string tag, input logic [1:0] cons, input logic stl,
                        input logic rd, input logic [PW-1:0] rpc,
                        input logic v0, input logic [PW-1:0] p0,
                        input logic v1, input logic [PW-1:0] p1,
                        input logic h, input logic [PW-1:0] epc);
        exp_t e;
        @(negedge clk);
        #1;
        consumed    = cons;
        stall       = stl;
        redirect    = rd;
        redirect_pc = rpc;
        e = '{v0: v0, p0: p0, v1: v1, p1: p1, h: h, pc: epc, tag: tag};
        sb.push_back(e);
        @(posedge clk);
        #1;
        consumed = 2'd0;
        stall    = 1'b0;
        redirect = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_vld0"}, 32'(if_vld0), 32'(e.v0));
        check({e.tag, "_vld1"}, 32'(if_vld1), 32'(e.v1));
        check({e.tag, "_halted"}, 32'(halted), 32'(e.h));
        check({e.tag, "_addr0"}, 32'(addr0), 32'(e.pc));
        check({e.tag, "_addr1"}, 32'(addr1), 32'(PW'(e.pc + 1)));
        if (e.v0) begin
            check({e.tag, "_pc0"}, 32'(if_pc0), 32'(e.p0));
            check({e.tag, "_instr0"}, if_instr0, mem_word(e.p0));
        end
        if (e.v1) begin
            check({e.tag, "_pc1"}, 32'(if_pc1), 32'(e.p1));
            check({e.tag, "_instr1"}, if_instr1, mem_word(e.p1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Sequential pair fill from reset
        step("fill01", 2'd0, 0, 0, '0, 1, 14'd0, 1, 14'd1, 0, 14'd2);
        step("fill23", 2'd2, 0, 0, '0, 1, 14'd2, 1, 14'd3, 0, 14'd4);
        step("fill45", 2'd2, 0, 0, '0, 1, 14'd4, 1, 14'd5, 0, 14'd6);

        // Partial consume shifts slot1 down; zero consume holds
        step("cons1", 2'd1, 0, 0, '0, 1, 14'd5, 1, 14'd6, 0, 14'd7);
        step("cons0", 2'd0, 0, 0, '0, 1, 14'd5, 1, 14'd6, 0, 14'd7);

        // Redirect beats stall and consumed
        step("redir", 2'd2, 1, 1, 14'h0200, 0, '0, 0, '0, 0, 14'h0200);
        step("redir_fill", 2'd0, 0, 0, '0, 1, 14'h0200, 1, 14'h0201, 0, 14'h0202);
        step("stall", 2'd2, 1, 0, '0, 1, 14'h0200, 1, 14'h0201, 0, 14'h0202);

        // HALT in slot1
        halt_en   = 1'b1;
        halt_addr = 14'd7;
        step("h7_redir", 2'd0, 0, 1, 14'd6, 0, '0, 0, '0, 0, 14'd6);
        step("h7_fill", 2'd0, 0, 0, '0, 1, 14'd6, 1, 14'd7, 1, 14'd8);
        step("h7_hold", 2'd0, 0, 0, '0, 1, 14'd6, 1, 14'd7, 1, 14'd8);
        step("h7_drain1", 2'd1, 0, 0, '0, 1, 14'd7, 0, '0, 1, 14'd8);
        step("h7_drain2", 2'd1, 0, 0, '0, 0, '0, 0, '0, 1, 14'd8);
        step("h7_nofill", 2'd0, 0, 0, '0, 0, '0, 0, '0, 1, 14'd8);

        // HALT in slot0 kills the younger fill
        halt_addr = 14'd6;
        step("h6_redir", 2'd0, 0, 1, 14'd6, 0, '0, 0, '0, 0, 14'd6);
        step("h6_fill", 2'd0, 0, 0, '0, 1, 14'd6, 0, '0, 1, 14'd7);
        step("h6_drain", 2'd1, 0, 0, '0, 0, '0, 0, '0, 1, 14'd7);
        step("h6_nofill", 2'd0, 0, 0, '0, 0, '0, 0, '0, 1, 14'd7);

        // Address wrap
        halt_en = 1'b0;
        step("wrap_redir", 2'd0, 0, 1, 14'h3FFF, 0, '0, 0, '0, 0, 14'h3FFF);
        step("wrap_fill", 2'd0, 0, 0, '0, 1, 14'h3FFF, 1, 14'h0000, 0, 14'h0001);
        step("wrap_next", 2'd2, 0, 0, '0, 1, 14'h0001, 1, 14'h0002, 0, 14'h0003);

        // Async reset while halted with valid slots
        halt_en   = 1'b1;
        halt_addr = 14'h0011;
        step("r_redir", 2'd0, 0, 1, 14'h0010, 0, '0, 0, '0, 0, 14'h0010);
        step("r_fill", 2'd0, 0, 0, '0, 1, 14'h0010, 1, 14'h0011, 1, 14'h0012);
        #1;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        #1;
        rst = 1'b0;
        halt_en = 1'b0;
        step("r_resume", 2'd0, 0, 0, '0, 1, 14'd0, 1, 14'd1, 0, 14'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
